// File: rtl/sdes_block_controller_pkg.sv
// ============================================================================
//  Module      : sdes_pkg
//  Description : Shared S-DES types, permutation/S-box tables and helper
//                functions for the iterative block controller. Bit vectors
//                are held MSB-first, so S-DES bit n of a W-bit word sits at
//                vector index W-n.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND1 = 2'd1,
        ST_ROUND2 = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Permutation tables, 1-based source positions as in the S-DES definition
    localparam logic [3:0] C_P10   [10] = '{4'd3, 4'd5, 4'd2, 4'd7, 4'd4, 4'd10, 4'd1, 4'd9, 4'd8, 4'd6};
    localparam logic [3:0] C_P8    [8]  = '{4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd5, 4'd10, 4'd9};
    localparam logic [3:0] C_IP    [8]  = '{4'd2, 4'd6, 4'd3, 4'd1, 4'd4, 4'd8, 4'd5, 4'd7};
    localparam logic [3:0] C_IPINV [8]  = '{4'd4, 4'd1, 4'd3, 4'd5, 4'd7, 4'd2, 4'd8, 4'd6};
    localparam logic [3:0] C_EP    [8]  = '{4'd4, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd4, 4'd1};
    localparam logic [3:0] C_P4    [4]  = '{4'd2, 4'd4, 4'd3, 4'd1};

    // S-boxes indexed [row][column]
    localparam logic [1:0] C_S0 [4][4] = '{
        '{2'd1, 2'd0, 2'd3, 2'd2},
        '{2'd3, 2'd2, 2'd1, 2'd0},
        '{2'd0, 2'd2, 2'd1, 2'd3},
        '{2'd3, 2'd1, 2'd3, 2'd2}
    };
    localparam logic [1:0] C_S1 [4][4] = '{
        '{2'd0, 2'd1, 2'd2, 2'd3},
        '{2'd2, 2'd0, 2'd1, 2'd3},
        '{2'd3, 2'd0, 2'd1, 2'd0},
        '{2'd2, 2'd1, 2'd0, 2'd3}
    };

    function automatic logic [9:0] f_p10(input logic [9:0] k);
        logic [9:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd10; i = i + 4'd1) begin
            r[4'd9 - i] = k[4'd10 - C_P10[i]];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_p8(input logic [9:0] k);
        logic [7:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd8; i = i + 4'd1) begin
            r[3'(4'd7 - i)] = k[4'd10 - C_P8[3'(i)]];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_ip(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd8; i = i + 4'd1) begin
            r[3'(4'd7 - i)] = d[3'(4'd8 - C_IP[3'(i)])];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_ipinv(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd8; i = i + 4'd1) begin
            r[3'(4'd7 - i)] = d[3'(4'd8 - C_IPINV[3'(i)])];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_ep(input logic [3:0] n);
        logic [7:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd8; i = i + 4'd1) begin
            r[3'(4'd7 - i)] = n[2'(4'd4 - C_EP[3'(i)])];
        end
        return r;
    endfunction

    function automatic logic [3:0] f_p4(input logic [3:0] n);
        logic [3:0] r;
        r = '0;
        for (logic [3:0] i = 4'd0; i < 4'd4; i = i + 4'd1) begin
            r[2'(4'd3 - i)] = n[2'(4'd4 - C_P4[2'(i)])];
        end
        return r;
    endfunction

    // Row from outer bits (1,4), column from inner bits (2,3)
    function automatic logic [1:0] f_s0(input logic [3:0] x);
        return C_S0[{x[3], x[0]}][{x[2], x[1]}];
    endfunction

    function automatic logic [1:0] f_s1(input logic [3:0] x);
        return C_S1[{x[3], x[0]}][{x[2], x[1]}];
    endfunction

    // Rotate each 5-bit half of the key left by one position
    function automatic logic [9:0] f_ls1(input logic [9:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    // Rotate each 5-bit half of the key left by two positions
    function automatic logic [9:0] f_ls2(input logic [9:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

    function automatic logic [7:0] f_sw(input logic [7:0] d);
        return {d[3:0], d[7:4]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdes_block_controller_if.sv
// ============================================================================
//  Module      : sdes_block_controller_if
//  Description : Key-load, input-block and output-block handshake bundle of
//                the S-DES controller. master = host/bench, slave = engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdes_block_controller_if;
    logic       key_load;
    logic [9:0] key_in;
    logic       key_ready;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    modport master (
        output key_load, key_in, in_valid, in_data, in_decrypt, out_ready,
        input  key_ready, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  key_load, key_in, in_valid, in_data, in_decrypt, out_ready,
        output key_ready, in_ready, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/sdes_block_controller_fk.sv
// ============================================================================
//  Module      : sdes_fk
//  Description : Combinational S-DES round function
//                fk(L|R, K) = (L xor P4(S0|S1(EP(R) xor K))) | R.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [7:0] subkey_i,
    output logic [7:0] data_o
);

    logic [7:0] w_mix;
    logic [3:0] w_sbox;

    assign w_mix  = f_ep(data_i[3:0]) ^ subkey_i;
    assign w_sbox = {f_s0(w_mix[7:4]), f_s1(w_mix[3:0])};
    assign data_o = {data_i[7:4] ^ f_p4(w_sbox), data_i[3:0]};

endmodule

`default_nettype wire

// File: rtl/sdes_block_controller.sv
// ============================================================================
//  Module      : sdes_block_controller
//  Description : Iterative S-DES engine. Holds the key schedule, accepts one
//                8-bit block at a time and runs both Feistel rounds through a
//                single shared fk datapath, presenting the result on a
//                valid/ready output.
//  Options     : SDES_BACKTOBACK_EN - allow a new block to be accepted in the
//                same cycle the previous result is handed off.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdes_block_controller
    import sdes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    sdes_block_controller_if.slave bus
);

    state_t     state_q, state_d;
    logic       key_loaded_q, key_loaded_d;
    logic [7:0] k1_q, k1_d;
    logic [7:0] k2_q, k2_d;
    logic [7:0] data_q, data_d;
    logic       mode_q, mode_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;

    logic [9:0] w_key_ls1;
    logic [7:0] w_key_k1;
    logic [7:0] w_key_k2;
    logic [7:0] w_fk_key;
    logic [7:0] w_fk_out;
    logic       w_in_ready;
    logic       w_in_accept;

    // Key schedule straight from the key input; registered only on a load
    assign w_key_ls1 = f_ls1(f_p10(bus.key_in));
    assign w_key_k1  = f_p8(w_key_ls1);
    assign w_key_k2  = f_p8(f_ls2(w_key_ls1));

    // Round 1 uses K1 for encrypt, round 2 the other subkey; decrypt swaps them
    assign w_fk_key = (state_q == ST_ROUND1) ? (mode_q ? k2_q : k1_q)
                                             : (mode_q ? k1_q : k2_q);

    sdes_fk u_fk (
        .data_i   (data_q),
        .subkey_i (w_fk_key),
        .data_o   (w_fk_out)
    );

`ifdef SDES_BACKTOBACK_EN
    assign w_in_ready = ((state_q == ST_IDLE) & key_loaded_q & ~bus.key_load) |
                        ((state_q == ST_DONE) & bus.out_ready & key_loaded_q);
`else
    assign w_in_ready = (state_q == ST_IDLE) & key_loaded_q & ~bus.key_load;
`endif
    assign w_in_accept = bus.in_valid & w_in_ready;

    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != ST_IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            key_loaded_q <= 1'b0;
            k1_q         <= '0;
            k2_q         <= '0;
            data_q       <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_loaded_q <= key_loaded_d;
            k1_q         <= k1_d;
            k2_q         <= k2_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Next-state sequencing: key load beats a same-cycle block in IDLE
    always_comb begin
        state_d      = state_q;
        key_loaded_d = key_loaded_q;
        k1_d         = k1_q;
        k2_d         = k2_q;
        data_d       = data_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.key_load) begin
                    k1_d         = w_key_k1;
                    k2_d         = w_key_k2;
                    key_loaded_d = 1'b1;
                end else if (w_in_accept) begin
                    data_d  = f_ip(bus.in_data);
                    mode_d  = bus.in_decrypt;
                    state_d = ST_ROUND1;
                end
            end
            ST_ROUND1: begin
                data_d  = f_sw(w_fk_out);
                state_d = ST_ROUND2;
            end
            ST_ROUND2: begin
                out_data_d  = f_ipinv(w_fk_out);
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef SDES_BACKTOBACK_EN
                    if (w_in_accept) begin
                        data_d  = f_ip(bus.in_data);
                        mode_d  = bus.in_decrypt;
                        state_d = ST_ROUND1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
